// File: rtl/ext_irq_ctrl_if.sv
// Register-port bundle between the processor's bus bridge and the external interrupt controller.
// The master drives single-cycle read/write strobes; the slave returns registered read data.
interface ext_irq_ctrl_if #(
    parameter int unsigned ADDR_W = 3
) ();
    logic [ADDR_W-1:0] reg_addr;
    logic [31:0]       reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [31:0]       reg_rdata;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_we,
        output reg_re,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_we,
        input  reg_re,
        output reg_rdata
    );
endinterface

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: latches rising edges into pending bits, masks them with ENABLE,
// and drives the core's EXT line through an assert / claim / complete handshake.
module ext_irq_ctrl #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned ADDR_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    ext_irq_ctrl_if.slave      bus,
    output logic               ext
);
    typedef enum logic [1:0] {StIdle, StAssert, StInService} state_e;

    localparam logic [ADDR_W-1:0] AddrPending  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] AddrEnable   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] AddrClaim    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] AddrComplete = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] AddrStatus   = ADDR_W'(4);

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] prev_q, pend_q, pend_d, en_q, en_d;
    logic [4:0]         id_q, id_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               ext_q;

    logic [NUM_SRC-1:0] rise, active, sel_oh;
    logic [4:0]         sel_id;
    logic               req, claim, complete, w1c, en_wr;
    logic               unused_wdata;

    assign rise         = irq_src & ~prev_q;
    assign active       = pend_q & en_q;
    assign req          = |active;
    assign unused_wdata = ^bus.reg_wdata;

    // Lowest index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        sel_id = '0;
        sel_oh = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (active[i]) begin
                sel_id    = 5'(i);
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
        end
    end

    assign claim    = bus.reg_re && (bus.reg_addr == AddrClaim) && (state_q == StAssert) && req;
    assign complete = bus.reg_we && (bus.reg_addr == AddrComplete) && (state_q == StInService);
    assign w1c      = bus.reg_we && (bus.reg_addr == AddrPending);
    assign en_wr    = bus.reg_we && (bus.reg_addr == AddrEnable);

    always_comb begin
        pend_d = pend_q;
        if (claim) pend_d = pend_d & ~sel_oh;
        if (w1c)   pend_d = pend_d & ~bus.reg_wdata[NUM_SRC-1:0];
        // A fresh edge beats any clear in the same cycle.
        pend_d = pend_d | rise;
        en_d   = en_wr ? bus.reg_wdata[NUM_SRC-1:0] : en_q;
        id_d   = claim ? sel_id : id_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (req) state_d = StAssert;
            StAssert: begin
                if (claim)     state_d = StInService;
                else if (!req) state_d = StIdle;
            end
            StInService: if (complete) state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    // Reads see pre-write register values; rdata holds between reads.
    always_comb begin
        rdata_d = rdata_q;
        if (bus.reg_re) begin
            rdata_d = '0;
            case (bus.reg_addr)
                AddrPending: rdata_d[NUM_SRC-1:0] = pend_q;
                AddrEnable:  rdata_d[NUM_SRC-1:0] = en_q;
                AddrClaim:   if (claim) rdata_d = 32'(sel_id) + 32'd1;
                AddrStatus:  rdata_d[5:0] = {id_q, state_q == StInService};
                default:     rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            prev_q  <= '0;
            pend_q  <= '0;
            en_q    <= '0;
            id_q    <= '0;
            rdata_q <= '0;
            ext_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= irq_src;
            pend_q  <= pend_d;
            en_q    <= en_d;
            id_q    <= id_d;
            rdata_q <= rdata_d;
            ext_q   <= (state_d == StAssert);
        end
    end

    assign ext           = ext_q;
    assign bus.reg_rdata = rdata_q;
endmodule
